truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter HOLD_CYCLES, default 50, SHALL set the cycles each input vector is held on the gate under test; legal range 1..65535.
REQ-002 Parameter CNT_W, default 16, SHALL set the hold-counter width and SHALL be large enough to hold HOLD_CYCLES-1.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit, SHALL be a run request, sampled only in IDLE.
REQ-006 Port op_sel, input, 3 bits, SHALL select the expected gate: 0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved.
REQ-007 Port gate_a, output, 1 bit, SHALL be the registered a input driven to the gate under test.
REQ-008 Port gate_b, output, 1 bit, SHALL be the registered b input driven to the gate under test.
REQ-009 Port gate_y, input, 1 bit, SHALL be the gate-under-test output.
REQ-010 Port busy, output, 1 bit, SHALL be high from the cycle after start is accepted until done.
REQ-011 Port done, output, 1 bit, SHALL be a single-cycle completion pulse.
REQ-012 Port table_out, output, 4 bits, SHALL hold the captured gate_y, bit index {a,b}.
REQ-013 Port mismatch_cnt, output, 3 bits, SHALL count vectors whose capture differed from expected (0..4).
REQ-014 Port pass, output, 1 bit, SHALL be high when mismatch_cnt is 0 and op_sel was not 7.

Function
REQ-015 FSM SHALL have states IDLE, DRIVE, FINISH; reset state IDLE.
REQ-016 IDLE with start=1 SHALL latch op_sel, clear table_out, mismatch_cnt, pass, set vector index 0, hold counter 0, and go to DRIVE.
REQ-017 In DRIVE, {gate_a,gate_b} SHALL equal the 2-bit vector index, in order 00, 01, 10, 11.
REQ-018 Hold counter SHALL increment each DRIVE cycle; at count HOLD_CYCLES-1 gate_y SHALL be captured into table_out[index], compared with expected, the counter cleared, and the index advanced.
REQ-019 Capture of index 3 SHALL move the FSM to FINISH; FINISH SHALL assert done for one cycle, update pass, deassert busy, and return to IDLE.
REQ-020 done SHALL assert exactly 4*HOLD_CYCLES+1 cycles after the start-accept edge.
REQ-021 start while busy SHALL be ignored; op_sel changes during a run SHALL have no effect.
REQ-022 op_sel 7 SHALL still complete a full sweep, compare against expected 0, and force pass=0.
REQ-023 HOLD_CYCLES=1 SHALL capture every cycle with no idle gap between vectors.
REQ-024 table_out, mismatch_cnt, pass SHALL hold their values after done until the next accepted start.
REQ-025 In IDLE and FINISH, gate_a and gate_b SHALL be 0.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, busy=0, done=0, gate_a=0, gate_b=0, table_out=0, mismatch_cnt=0, pass=0.
REQ-027 Reset mid-run SHALL abort with no done pulse; the next run SHALL start from vector 00.

Structure
REQ-028 The op_sel encoding (gate_op enum) and the FSM state encoding SHALL live in a shared package, gate_pkg.
REQ-029 Expected-value calculation SHALL be a combinational sub-module, gate_ref_model (inputs op, a, b; output y).

Verification
REQ-030 op=5 XOR, gate_y=a^b, HOLD_CYCLES=50 -> done at cycle 201 after start; table_out=4'b0110, mismatch_cnt=0, pass=1.
REQ-031 op=2 NOT, gate_y=~a -> table_out=4'b0011, pass=1; op=3 NAND, gate_y=~(a&b) -> table_out=4'b0111, pass=1.
REQ-032 op=1 OR, gate_y stuck at 0 -> table_out=4'b0000, mismatch_cnt=3, pass=0.
REQ-033 rst_n pulsed low during vector 10 -> outputs zero immediately, no done; a new start sweeps 00..11 fully.
REQ-034 start re-asserted and op_sel changed mid-run -> no restart, result uses the original op; op=7 -> full sweep, pass=0.
REQ-035 HOLD_CYCLES=1, op=0 AND, ideal gate -> done 5 cycles after start, table_out=4'b1000, pass=1.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared encodings for the truth-table sweeper: gate operation select and
// sweep FSM states.
package gate_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NOT_A = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XOR   = 3'd5,
    OP_XNOR  = 3'd6,
    OP_RSVD  = 3'd7
  } gate_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_FINISH = 2'd2
  } sweep_state_e;

  // Index of the last {a,b} vector in a sweep.
  localparam logic [1:0] LAST_VEC = 2'd3;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational expected output of the selected gate for one {a,b} vector.
// The reserved op expects 0 on every vector.
module gate_ref_model
  import gate_pkg::*;
(
  input  gate_op_e op,
  input  logic     a,
  input  logic     b,
  output logic     y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_NOT_A: y = ~a;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XOR:   y = a ^ b;
      OP_XNOR:  y = ~(a ^ b);
      default:  y = 1'b0;
    endcase
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives the four {a,b} vectors onto a 2-input gate, holds each for
// HOLD_CYCLES, captures the response and grades it against the selected op.
//
// Handshake: start is a level request sampled only in IDLE; the accepting
// edge raises busy, and done pulses for one cycle on the edge that drops
// busy, 4*HOLD_CYCLES+1 cycles after the accepting edge.
module truth_table_sweeper
  import gate_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50,
  parameter int unsigned CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op_sel,
  output logic         gate_a,
  output logic         gate_b,
  input  logic         gate_y,
  output logic         busy,
  output logic         done,
  output logic [3:0]   table_out,
  output logic [2:0]   mismatch_cnt,
  output logic         pass,
  output sweep_state_e state_dbg
);

  sweep_state_e     state, state_d;
  gate_op_e         op_q;
  logic [1:0]       idx;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_last;
  logic             start_accept;
  logic             capture;
  logic             exp_y;

  assign hold_last = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));
  assign state_dbg = state;

  gate_ref_model u_ref (
    .op (op_q),
    .a  (idx[1]),
    .b  (idx[0]),
    .y  (exp_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d      = state;
    start_accept = 1'b0;
    capture      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_d      = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (hold_last) begin
          capture = 1'b1;
          if (idx == LAST_VEC) state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_AND;
      idx          <= 2'd0;
      hold_cnt     <= '0;
      gate_a       <= 1'b0;
      gate_b       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= 4'd0;
      mismatch_cnt <= 3'd0;
      pass         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_accept) begin
        op_q         <= gate_op_e'(op_sel);
        idx          <= 2'd0;
        hold_cnt     <= '0;
        gate_a       <= 1'b0;
        gate_b       <= 1'b0;
        busy         <= 1'b1;
        table_out    <= 4'd0;
        mismatch_cnt <= 3'd0;
        pass         <= 1'b0;
      end
      if (state == ST_DRIVE) begin
        if (capture) begin
          table_out[idx] <= gate_y;
          if (gate_y != exp_y) mismatch_cnt <= mismatch_cnt + 3'd1;
          hold_cnt <= '0;
          idx      <= idx + 2'd1;
          // Gate inputs return to 00 once the last vector has been captured.
          {gate_a, gate_b} <= (idx == LAST_VEC) ? 2'b00 : idx + 2'd1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
      if (state == ST_FINISH) begin
        done <= 1'b1;
        busy <= 1'b0;
        pass <= (mismatch_cnt == 3'd0) && (op_q != OP_RSVD);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a HOLD_CYCLES=50 and a HOLD_CYCLES=1 instance,
// each driving a behavioural gate whose response is a 4-entry truth table.
module tb_truth_table_sweeper;
  import gate_pkg::*;

  localparam int H0 = 50;
  localparam int H1 = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start [2];
  logic [2:0]   op_sel [2];
  logic         gate_a [2];
  logic         gate_b [2];
  logic         gate_y [2];
  logic         busy [2];
  logic         done [2];
  logic [3:0]   table_out [2];
  logic [2:0]   mismatch_cnt [2];
  logic         pass [2];
  sweep_state_e state_dbg [2];
  logic [3:0]   gut_tt [2];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign gate_y[0] = gut_tt[0][{gate_a[0], gate_b[0]}];
  assign gate_y[1] = gut_tt[1][{gate_a[1], gate_b[1]}];

  truth_table_sweeper #(.HOLD_CYCLES(H0), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .op_sel(op_sel[0]),
    .gate_a(gate_a[0]), .gate_b(gate_b[0]), .gate_y(gate_y[0]),
    .busy(busy[0]), .done(done[0]), .table_out(table_out[0]),
    .mismatch_cnt(mismatch_cnt[0]), .pass(pass[0]), .state_dbg(state_dbg[0])
  );

  truth_table_sweeper #(.HOLD_CYCLES(H1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .op_sel(op_sel[1]),
    .gate_a(gate_a[1]), .gate_b(gate_b[1]), .gate_y(gate_y[1]),
    .busy(busy[1]), .done(done[1]), .table_out(table_out[1]),
    .mismatch_cnt(mismatch_cnt[1]), .pass(pass[1]), .state_dbg(state_dbg[1])
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] gut;
    logic [3:0] exp_tab;
    logic [2:0] exp_mm;
    logic       exp_pass;
    string      name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference truth table of each op, built from the boolean rules with integers.
  function automatic logic [3:0] ideal_tt(input logic [2:0] op);
    logic [3:0] t;
    t = 4'd0;
    for (int v = 0; v < 4; v++) begin
      int a;
      int b;
      int y;
      a = v / 2;
      b = v % 2;
      case (op)
        3'd0: y = a * b;
        3'd1: y = (a + b > 0) ? 1 : 0;
        3'd2: y = 1 - a;
        3'd3: y = 1 - a * b;
        3'd4: y = (a + b == 0) ? 1 : 0;
        3'd5: y = (a + b) % 2;
        3'd6: y = 1 - (a + b) % 2;
        default: y = 0;
      endcase
      t[v] = (y != 0);
    end
    return t;
  endfunction

  task automatic run_sweep(input int d, input int hold, input logic [2:0] op,
                           input logic [3:0] tt, input bit disturb,
                           input logic [3:0] exp_tab, input logic [2:0] exp_mm,
                           input logic exp_pass, input string tag);
    int cyc;
    int exp_vec;
    bit got;
    bit order_ok;
    op_sel[d] = op;
    gut_tt[d] = tt;
    @(negedge clk);
    start[d] = 1'b1;
    @(posedge clk);
    #1 start[d] = 1'b0;
    check($sformatf("%s busy_on", tag), 32'(busy[d]), 32'd1);
    cyc = 0;
    got = 1'b0;
    order_ok = 1'b1;
    while (!got && cyc < 4 * hold + 20) begin
      exp_vec = (cyc < 4 * hold) ? cyc / hold : 0;
      if ({gate_a[d], gate_b[d]} != 2'(exp_vec)) order_ok = 1'b0;
      if (disturb && cyc == hold + 2) begin
        start[d]  = 1'b1;
        op_sel[d] = ~op;
      end
      if (disturb && cyc == hold + 4) start[d] = 1'b0;
      @(posedge clk);
      #1 cyc++;
      if (done[d]) got = 1'b1;
    end
    check($sformatf("%s done_latency", tag), 32'(cyc), 32'(4 * hold + 1));
    check($sformatf("%s vector_order", tag), 32'(order_ok), 32'd1);
    check($sformatf("%s table_out", tag), 32'(table_out[d]), 32'(exp_tab));
    check($sformatf("%s mismatch_cnt", tag), 32'(mismatch_cnt[d]), 32'(exp_mm));
    check($sformatf("%s pass", tag), 32'(pass[d]), 32'(exp_pass));
    check($sformatf("%s busy_off", tag), 32'(busy[d]), 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("%s done_single", tag), 32'(done[d]), 32'd0);
    check($sformatf("%s hold_result", tag),
          {24'd0, table_out[d], mismatch_cnt[d], pass[d]},
          {24'd0, exp_tab, exp_mm, exp_pass});
    op_sel[d] = op;
  endtask

  task automatic check_zero(input int d, input string tag);
    check($sformatf("%s busy", tag), 32'(busy[d]), 32'd0);
    check($sformatf("%s done", tag), 32'(done[d]), 32'd0);
    check($sformatf("%s gates", tag), 32'({gate_a[d], gate_b[d]}), 32'd0);
    check($sformatf("%s results", tag),
          {24'd0, table_out[d], mismatch_cnt[d], pass[d]}, 32'd0);
    check($sformatf("%s state", tag), 32'(state_dbg[d]), 32'(ST_IDLE));
  endtask

  vec_t vecs [6];

  initial begin
    logic [2:0] r_op;
    logic [3:0] r_tt;
    logic [3:0] ref_tt;
    logic [2:0] r_mm;
    bit saw_done;

    vecs[0] = '{3'd5, 4'b0110, 4'b0110, 3'd0, 1'b1, "xor_ideal"};
    vecs[1] = '{3'd2, 4'b0011, 4'b0011, 3'd0, 1'b1, "not_ideal"};
    vecs[2] = '{3'd3, 4'b0111, 4'b0111, 3'd0, 1'b1, "nand_ideal"};
    vecs[3] = '{3'd1, 4'b0000, 4'b0000, 3'd3, 1'b0, "or_stuck0"};
    vecs[4] = '{3'd7, 4'b0000, 4'b0000, 3'd0, 1'b0, "rsvd_zero"};
    vecs[5] = '{3'd6, 4'b1101, 4'b1101, 3'd1, 1'b0, "xnor_fault"};

    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      op_sel[d] = 3'd0;
      gut_tt[d] = 4'd0;
    end

    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_sweep(0, H0, vecs[i].op, vecs[i].gut, 1'b0, vecs[i].exp_tab,
                vecs[i].exp_mm, vecs[i].exp_pass, vecs[i].name);

    // Mid-run start and op_sel change must not disturb an AND sweep.
    run_sweep(0, H0, 3'd0, 4'b1000, 1'b1, 4'b1000, 3'd0, 1'b1, "disturb_and");
    // Reserved op with a gate that answers 1 everywhere.
    run_sweep(0, H0, 3'd7, 4'b1111, 1'b1, 4'b1111, 3'd4, 1'b0, "rsvd_ones");

    // Single-cycle hold instance.
    run_sweep(1, H1, 3'd0, 4'b1000, 1'b0, 4'b1000, 3'd0, 1'b1, "h1_and");

    // Reset during vector 10.
    op_sel[0] = 3'd5;
    gut_tt[0] = 4'b0110;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (2 * H0 + 5) @(posedge clk);
    #2;
    check("midrun vector10", 32'({gate_a[0], gate_b[0]}), 32'd2);
    rst_n = 1'b0;
    #1;
    check_zero(0, "midrun_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (4 * H0 + 10) begin
      @(posedge clk);
      #1 if (done[0]) saw_done = 1'b1;
    end
    check("midrun no_done", 32'(saw_done), 32'd0);
    run_sweep(0, H0, 3'd5, 4'b0110, 1'b0, 4'b0110, 3'd0, 1'b1, "after_reset");

    // Randomized gates graded against the reference truth tables.
    for (int i = 0; i < 30; i++) begin
      int d;
      d = (i < 6) ? 0 : 1;
      r_op = 3'($urandom_range(0, 7));
      r_tt = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) r_tt = ideal_tt(r_op);
      ref_tt = ideal_tt(r_op);
      r_mm = 3'($countones(r_tt ^ ref_tt));
      run_sweep(d, (d == 0) ? H0 : H1, r_op, r_tt, 1'b0, r_tt, r_mm,
                (r_mm == 3'd0) && (r_op != 3'd7), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
